// File: rtl/phy_pkg.sv
// ----------------------------------------------------------------------------
// phy_pkg
// Shared definitions for the serial-to-parallel receive path:
//   COMMA_BC       : idle/alignment character
//   LOCK_COUNT_DEF : default number of aligned commas needed to go active
//   rx_state_t     : alignment FSM states
// ----------------------------------------------------------------------------
package phy_pkg;

    localparam logic [7:0]  COMMA_BC       = 8'hBC;
    localparam int unsigned LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        ACTIVE
    } rx_state_t;

endpackage

// File: rtl/serial_paralelo_rx_comma_det.sv
// ----------------------------------------------------------------------------
// comma_det
// Combinational comparison of a candidate byte against the comma character.
// Ports:
//   i_cand     [7:0] in  : candidate byte (value the shift register takes next)
//   o_is_comma       out : 1 when i_cand equals COMMA
// ----------------------------------------------------------------------------
module comma_det
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_BC
) (
    input  logic [7:0] i_cand,
    output logic       o_is_comma
);

    assign o_is_comma = (i_cand == COMMA);

endmodule

// File: rtl/serial_paralelo_rx.sv
// ----------------------------------------------------------------------------
// serial_paralelo_rx
// Serial-to-parallel receiver with comma-based byte alignment. Searches the
// bit stream for COMMA at any bit offset, confirms LOCK_COUNT aligned commas,
// then recovers one byte every 8 clocks. Commas in the active stream are
// treated as idle and never presented as valid data.
//
// Ports:
//   clk_32f             in  : bit clock, one serial bit per rising edge
//   reset_L             in  : asynchronous active-low reset
//   serial_in           in  : serial data, MSB of each byte first
//   data_out      [7:0] out : last recovered non-comma byte
//   valid_out           out : data_out was loaded in the current byte period
//   active              out : link aligned and locked (sticky until reset)
//   align_err_cnt [7:0] out : LOCKING->SEARCH fallbacks, saturating
//                             (present only when S2P_ERR_CNT_EN is defined)
//
// Build option: define S2P_ERR_CNT_EN to add the alignment-error counter.
// ----------------------------------------------------------------------------
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter logic [7:0]  COMMA      = COMMA_BC,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
`ifdef S2P_ERR_CNT_EN
    ,
    output logic [7:0] align_err_cnt
`endif
);

    localparam logic [7:0] LC8 = LOCK_COUNT[7:0];

    rx_state_t  r_state;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_bc_cnt;

    logic [7:0] w_cand;
    logic       w_is_comma;
    logic       w_boundary;
    logic [7:0] w_bc_next;
    logic       w_unused_sr_msb;

    // Candidate is the byte the shift register will hold after this edge,
    // so a match is acted on in the same cycle its last bit arrives.
    assign w_cand          = {r_sr[6:0], serial_in};
    assign w_boundary      = (r_bit_cnt == 3'd7);
    assign w_bc_next       = r_bc_cnt + 8'd1;
    // The oldest bit shifts out and is never part of the candidate.
    assign w_unused_sr_msb = r_sr[7];

    comma_det #(
        .COMMA (COMMA)
    ) u_comma_det (
        .i_cand     (w_cand),
        .o_is_comma (w_is_comma)
    );

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state       <= SEARCH;
            r_sr          <= '0;
            r_bit_cnt     <= '0;
            r_bc_cnt      <= '0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            active        <= 1'b0;
`ifdef S2P_ERR_CNT_EN
            align_err_cnt <= '0;
`endif
        end else begin
            r_sr <= w_cand;

            unique case (r_state)
                SEARCH: begin
                    // Bit position is unknown here, so every cycle is checked.
                    valid_out <= 1'b0;
                    if (w_is_comma) begin
                        r_bit_cnt <= '0;
                        r_bc_cnt  <= 8'd1;
                        if (LOCK_COUNT == 1) begin
                            r_state <= ACTIVE;
                            active  <= 1'b1;
                        end else begin
                            r_state <= LOCKING;
                        end
                    end
                end

                LOCKING: begin
                    valid_out <= 1'b0;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            r_bc_cnt <= w_bc_next;
                            if (w_bc_next == LC8) begin
                                r_state <= ACTIVE;
                                active  <= 1'b1;
                            end
                        end else begin
                            r_state  <= SEARCH;
                            r_bc_cnt <= '0;
`ifdef S2P_ERR_CNT_EN
                            if (align_err_cnt != 8'hFF) begin
                                align_err_cnt <= align_err_cnt + 8'd1;
                            end
`endif
                        end
                    end
                end

                ACTIVE: begin
                    // No loss-of-lock detection: ACTIVE is left only by reset.
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_comma) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= w_cand;
                            valid_out <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
module tb_serial_paralelo_rx;
    import phy_pkg::*;

    logic       clk_32f   = 1'b0;
    logic       reset_L   = 1'b0;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef S2P_ERR_CNT_EN
    logic [7:0] align_err_cnt;
`endif

    always #5 clk_32f = ~clk_32f;

    serial_paralelo_rx #(
        .COMMA      (8'hBC),
        .LOCK_COUNT (4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef S2P_ERR_CNT_EN
        ,
        .align_err_cnt (align_err_cnt)
`endif
    );

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        serial_in = b;
    endtask

    // Drives 8 bits MSB first, returns 1 time unit after the edge that
    // samples the last bit.
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
        @(posedge clk_32f);
        #1;
    endtask

    // Byte sent while locked: queue what the receiver must present at its boundary.
    task automatic send_active(input logic [7:0] v);
        exp_t e;
        if (v == COMMA_BC) begin
            e.valid = 1'b0;
            e.data  = model_data;
        end else begin
            model_data = v;
            e.valid    = 1'b1;
            e.data     = v;
        end
        exp_q.push_back(e);
        send_byte(v);
    endtask

    // Monitor: follows the byte grid from the moment active rises and checks
    // outputs at each boundary (scoreboard pop) and stability in between.
    initial begin : monitor
        logic       tracking;
        int         k;
        logic [7:0] held_d;
        logic       held_v;
        exp_t       e;
        tracking = 1'b0;
        k        = 0;
        held_d   = '0;
        held_v   = 1'b0;
        forever begin
            @(posedge clk_32f);
            #1;
            if (!reset_L || !active) begin
                tracking = 1'b0;
            end else if (!tracking) begin
                tracking = 1'b1;
                k        = 0;
                held_d   = data_out;
                held_v   = valid_out;
            end else begin
                k++;
                if (k == 8) begin
                    k = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_boundary: valid=%0b data=%0h with nothing queued", valid_out, data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("boundary_valid", valid_out, e.valid);
                        chk("boundary_data", data_out, e.data);
                    end
                    held_d = data_out;
                    held_v = valid_out;
                end else begin
                    chk("hold_valid", valid_out, held_v);
                    chk("hold_data", data_out, held_d);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        // Power-on reset for 3 cycles
        reset_L   = 1'b0;
        serial_in = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_active", active, 1'b0);
`ifdef S2P_ERR_CNT_EN
        chk("rst_err", align_err_cnt, 8'd0);
`endif
        @(negedge clk_32f);
        reset_L    = 1'b1;
        model_data = 8'h00;

        // Lock: random 3-bit misalignment, 4 commas, then data
        repeat (3) send_bit(1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hBC);
            chk("lock_active", active, (i == 3) ? 1 : 0);
        end
        send_active(8'hA5);
        // Idle comma between data while active
        send_active(8'h3C);
        send_active(8'hBC);
        send_active(8'h7F);
        // Back-to-back data
        for (int v = 0; v < 32; v++) begin
            send_active(8'(v));
        end
        send_active(8'hBC);
        // Partial byte, then asynchronous reset between clock edges
        repeat (4) send_bit(1'b1);
        @(posedge clk_32f);
        #3;
        chk("queue_drained_1", exp_q.size(), 0);
        reset_L = 1'b0;
        #1;
        chk("async_rst_data", data_out, 8'h00);
        chk("async_rst_valid", valid_out, 1'b0);
        chk("async_rst_active", active, 1'b0);
        repeat (2) @(posedge clk_32f);
        @(negedge clk_32f);
        reset_L    = 1'b1;
        model_data = 8'h00;

        // Lock failure: 3 commas, a data byte, then a full comma run
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hBC);
            chk("fail_active_run1", active, 1'b0);
        end
        send_byte(8'h12);
        chk("fail_active_break", active, 1'b0);
`ifdef S2P_ERR_CNT_EN
        chk("fail_err_cnt", align_err_cnt, 8'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hBC);
            chk("relock_active", active, (i == 3) ? 1 : 0);
        end
        send_active(8'h5A);
        send_active(8'hBC);
        repeat (3) send_bit(1'b0);
        @(posedge clk_32f);
        #3;
        chk("queue_drained_2", exp_q.size(), 0);
        reset_L = 1'b0;
        #1;
        chk("rst2_data", data_out, 8'h00);
        chk("rst2_active", active, 1'b0);
        repeat (2) @(posedge clk_32f);
        @(negedge clk_32f);
        reset_L    = 1'b1;
        model_data = 8'h00;

`ifdef S2P_ERR_CNT_EN
        // Counter saturation: 260 comma/data fallbacks
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hBC);
            send_byte(8'h12);
        end
        chk("sat_err_cnt", align_err_cnt, 8'd255);
        chk("sat_active", active, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
